// File: rtl/cpu4_control_sequencer.sv
// Fetch/decode/execute controller for the 4-bit microprocessor datapath.
// Each instruction takes 3 cycles. Strobes are decoded from the state, and also from the opcode in EXEC.
module cpu4_control_sequencer #(
  parameter bit ILLEGAL_HALTS = 1'b0,
  parameter bit AUTO_RUN      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic       ir_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_en,
  output logic       acc_sel,
  output logic       b_en,
  output logic       out_en,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ir_en     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_en    = 1'b0;
    acc_sel   = 1'b0;
    b_en      = 1'b0;
    out_en    = 1'b0;
    alu_op    = 2'b00;
    busy      = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: begin
        if (run || AUTO_RUN) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        ir_en     = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        busy      = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = (opcode == 4'hF) ? HALT : EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        case (opcode)
          4'h1: begin acc_en = 1'b1; acc_sel = 1'b1; end
          4'h2: b_en = 1'b1;
          4'h3: begin acc_en = 1'b1; alu_op = 2'b00; end
          4'h4: begin acc_en = 1'b1; alu_op = 2'b01; end
          4'h5: begin acc_en = 1'b1; alu_op = 2'b10; end
          4'h6: begin acc_en = 1'b1; alu_op = 2'b11; end
          4'h7: out_en = 1'b1;
          4'h8: pc_load = 1'b1;
          4'h9: pc_load = zero_flag;
          4'hA, 4'hB, 4'hC, 4'hD, 4'hE: illegal = 1'b1;
          default: ;
        endcase
        if (illegal && ILLEGAL_HALTS) state_nxt = HALT;
        else                          state_nxt = run ? FETCH : IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu4_control_sequencer.sv
// Bench for the cpu4_control_sequencer, with two parameterisations driven from shared inputs.
// Each DUT is compared every cycle against an instruction-level reference model.
module tb_cpu4_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, zero_flag;
  logic [3:0] opcode;

  logic       ir_en0, pc_inc0, pc_load0, acc_en0, acc_sel0, b_en0, out_en0, busy0, halted0, illegal0;
  logic [1:0] alu_op0;
  logic       ir_en1, pc_inc1, pc_load1, acc_en1, acc_sel1, b_en1, out_en1, busy1, halted1, illegal1;
  logic [1:0] alu_op1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk = 1'b0;

  // Position within an instruction: 0 idle, 1 fetch, 2 decode, 3 exec, 4 halted.
  int ph0 = 0;
  int ph1 = 0;

  always #5 clk = ~clk;

  cpu4_control_sequencer #(.ILLEGAL_HALTS(1'b0), .AUTO_RUN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero_flag(zero_flag),
    .ir_en(ir_en0), .pc_inc(pc_inc0), .pc_load(pc_load0), .acc_en(acc_en0),
    .acc_sel(acc_sel0), .b_en(b_en0), .out_en(out_en0), .alu_op(alu_op0),
    .busy(busy0), .halted(halted0), .illegal(illegal0)
  );

  cpu4_control_sequencer #(.ILLEGAL_HALTS(1'b1), .AUTO_RUN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero_flag(zero_flag),
    .ir_en(ir_en1), .pc_inc(pc_inc1), .pc_load(pc_load1), .acc_en(acc_en1),
    .acc_sel(acc_sel1), .b_en(b_en1), .out_en(out_en1), .alu_op(alu_op1),
    .busy(busy1), .halted(halted1), .illegal(illegal1)
  );

  // Output vector: {ir_en,pc_inc,pc_load,acc_en,acc_sel,b_en,out_en,alu_op,busy,halted,illegal}
  function automatic logic [12:0] expect_out(input int ph, input logic [3:0] op_in, input logic z);
    int o;
    logic ir, inc, ld, acc, sel, b, outp, bsy, hlt, ill;
    logic [1:0] alu;
    o   = int'(op_in);
    ir  = (ph == 1);
    inc = (ph == 2);
    bsy = (ph >= 1 && ph <= 3);
    hlt = (ph == 4);
    ld  = (ph == 3) && (o == 8 || (o == 9 && z));
    acc = (ph == 3) && (o == 1 || (o >= 3 && o <= 6));
    sel = (ph == 3) && (o == 1);
    b   = (ph == 3) && (o == 2);
    outp = (ph == 3) && (o == 7);
    ill = (ph == 3) && (o >= 10 && o <= 14);
    alu = ((ph == 3) && o >= 3 && o <= 6) ? 2'(o - 3) : 2'b00;
    return {ir, inc, ld, acc, sel, b, outp, alu, bsy, hlt, ill};
  endfunction

  function automatic int next_ph(input int ph, input logic rs, input logic r,
                                 input logic [3:0] op_in, input bit ih, input bit ar);
    int o;
    o = int'(op_in);
    if (rs) return 0;
    case (ph)
      0: return (r || ar) ? 1 : 0;
      1: return 2;
      2: return (o == 15) ? 4 : 3;
      3: begin
        if (ih && o >= 10 && o <= 14) return 4;
        return r ? 1 : 0;
      end
      default: return 4;
    endcase
  endfunction

  task automatic step(input string tag, input logic rs, input logic r,
                      input logic [3:0] op_in, input logic z);
    logic [12:0] obs0, obs1, exp0, exp1;
    @(negedge clk);
    reset = rs; run = r; opcode = op_in; zero_flag = z;
    #1;
    if (chk) begin
      obs0 = {ir_en0, pc_inc0, pc_load0, acc_en0, acc_sel0, b_en0, out_en0, alu_op0, busy0, halted0, illegal0};
      obs1 = {ir_en1, pc_inc1, pc_load1, acc_en1, acc_sel1, b_en1, out_en1, alu_op1, busy1, halted1, illegal1};
      exp0 = expect_out(ph0, op_in, z);
      exp1 = expect_out(ph1, op_in, z);
      vectors++;
      assert (obs0 === exp0) else begin
        miscompares++;
        $error("FAIL %s dut0 observed=%b expected=%b", tag, obs0, exp0);
      end
      vectors++;
      assert (obs1 === exp1) else begin
        miscompares++;
        $error("FAIL %s dut1 observed=%b expected=%b", tag, obs1, exp1);
      end
    end
    @(posedge clk);
    ph0 = next_ph(ph0, rs, r, op_in, 1'b0, 1'b0);
    ph1 = next_ph(ph1, rs, r, op_in, 1'b1, 1'b1);
  endtask

  // Three cycles of one instruction with the opcode held steady.
  task automatic instr(input string tag, input logic [3:0] op_in, input logic z, input logic r);
    for (int i = 0; i < 3; i++) step(tag, 1'b0, r, op_in, z);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 4'h0; zero_flag = 1'b0;
    step("reset0", 1'b1, 1'b0, 4'h0, 1'b0);
    chk = 1'b1;
    step("reset1", 1'b1, 1'b0, 4'h0, 1'b0);
    step("idle", 1'b0, 1'b0, 4'h0, 1'b0);
    step("idle", 1'b0, 1'b0, 4'h0, 1'b0);
    step("start", 1'b0, 1'b1, 4'h1, 1'b0);

    instr("lda", 4'h1, 1'b0, 1'b1);
    instr("ldb", 4'h2, 1'b0, 1'b1);
    instr("add", 4'h3, 1'b0, 1'b1);
    instr("out", 4'h7, 1'b0, 1'b1);
    instr("sub", 4'h4, 1'b1, 1'b1);
    instr("and", 4'h5, 1'b0, 1'b1);
    instr("or", 4'h6, 1'b1, 1'b1);
    instr("jmp", 4'h8, 1'b0, 1'b1);
    instr("jz1", 4'h9, 1'b1, 1'b1);
    instr("jz0", 4'h9, 1'b0, 1'b1);
    instr("nop", 4'h0, 1'b0, 1'b1);
    instr("ill_b", 4'hB, 1'b0, 1'b1);
    instr("after_ill", 4'h1, 1'b0, 1'b1);

    step("reset_h", 1'b1, 1'b0, 4'h0, 1'b0);
    step("run_h", 1'b0, 1'b1, 4'hF, 1'b0);
    instr("hlt", 4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step("halt_hold", 1'b0, i[0], 4'(i), 1'b0);
    step("reset_rel", 1'b1, 1'b1, 4'h0, 1'b0);
    step("idle_rel", 1'b0, 1'b0, 4'h0, 1'b0);

    step("run_rs", 1'b0, 1'b1, 4'h3, 1'b0);
    step("fetch_rs", 1'b0, 1'b1, 4'h3, 1'b0);
    step("decode_rs", 1'b1, 1'b1, 4'h3, 1'b0);
    step("abandon", 1'b0, 1'b0, 4'h3, 1'b0);
    step("abandon2", 1'b0, 1'b1, 4'h3, 1'b0);
    step("fetch_rd", 1'b0, 1'b1, 4'h3, 1'b0);
    step("decode_rd", 1'b0, 1'b0, 4'h3, 1'b0);
    step("exec_rd", 1'b0, 1'b0, 4'h3, 1'b0);
    step("idle_rd", 1'b0, 1'b0, 4'h3, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic rs, r, z;
      logic [3:0] op_r;
      rs   = ($urandom_range(0, 24) == 0);
      r    = ($urandom_range(0, 7) != 0);
      z    = 1'($urandom);
      op_r = 4'($urandom);
      step("rand", rs, r, op_r, z);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
